// File: rtl/udma_l2_resp_pkg.sv
// Shared definitions for the uDMA L2 responder: default word width,
// out-of-range read pattern and the per-port request/response tags.
package udma_l2_resp_pkg;

  localparam int unsigned L2_DATA_WIDTH  = 32;
  localparam int unsigned L2_ADDR_WIDTH  = 32;
  localparam logic [31:0] L2_OOR_PATTERN = 32'hDEAD_BEEF;

  // Routing fields of one port request (width-independent part).
  typedef struct packed {
    logic                     req;
    logic                     wen;
    logic [L2_ADDR_WIDTH-1:0] addr;
  } l2_req_t;

  // Response pending on a port for the cycle after its grant.
  typedef struct packed {
    logic valid;
    logic is_read;
    logic oor;
  } l2_rsp_t;

endpackage

// File: rtl/udma_l2_sram.sv
// Single-port word RAM with byte enables and one-cycle read latency.
// Ports: clk_i; req_i/we_i select an access, addr_i word index,
//        be_i byte enables (writes only), wdata_i write data,
//        rdata_o read data valid the cycle after a read request.
module udma_l2_sram
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = 4096,
  localparam int unsigned AW        = $clog2(NUM_WORDS),
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage and read register are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < int'(BE_WIDTH); b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/udma_l2_responder.sv
// L2 memory responder for the uDMA: two symmetric ports (ro, wo) share one
// single-port array through a round-robin arbiter; each grant is answered
// with a one-cycle rvalid on the granted port.
// Ports: sys_clk_i/sys_rst_i clock and sync active-high reset, stall_i
//        blocks all grants; per port x in {ro,wo}: x_req_i, x_gnt_o
//        (combinational), x_wen_i (1 = read), x_addr_i byte address,
//        x_be_i, x_wdata_i, x_rvalid_o, x_rdata_o (held between responses).
module udma_l2_responder
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic                    stall_i,
  input  logic                    ro_req_i,
  output logic                    ro_gnt_o,
  input  logic                    ro_wen_i,
  input  logic [31:0]             ro_addr_i,
  input  logic [DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                    ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ro_rdata_o,
  input  logic                    wo_req_i,
  output logic                    wo_gnt_o,
  input  logic                    wo_wen_i,
  input  logic [31:0]             wo_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                    wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]   wo_rdata_o
);

  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned AW         = $clog2(NUM_WORDS);
  localparam int unsigned BYTE_SHIFT = $clog2(BE_WIDTH);
  localparam logic [32:0] MEM_BYTES  = 33'(NUM_WORDS) * 33'(BE_WIDTH);

  l2_req_t               ro_hdr, wo_hdr;
  logic                  ro_win_c, wo_win_c, contention_c, any_gnt_c;
  logic                  rr_q, rr_d;
  l2_rsp_t               ro_pend_q, ro_pend_d, wo_pend_q, wo_pend_d;
  logic [DATA_WIDTH-1:0] ro_rdata_q, ro_rdata_d, wo_rdata_q, wo_rdata_d;
  logic                  sel_wen;
  logic [31:0]           sel_addr, offset;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;
  logic [AW-1:0]         word_idx;
  logic [DATA_WIDTH-1:0] sram_rdata, oor_word, ro_rsp_data, wo_rsp_data;

  assign ro_hdr = '{req: ro_req_i, wen: ro_wen_i, addr: ro_addr_i};
  assign wo_hdr = '{req: wo_req_i, wen: wo_wen_i, addr: wo_addr_i};

  // Arbitration: a lone requester wins, otherwise rr_q picks the winner.
  always_comb begin
    contention_c = ro_hdr.req & wo_hdr.req;
    ro_win_c     = ro_hdr.req & (~wo_hdr.req | ~rr_q);
    wo_win_c     = wo_hdr.req & (~ro_hdr.req | rr_q);
  end

  assign ro_gnt_o  = ro_win_c & ~stall_i & ~sys_rst_i;
  assign wo_gnt_o  = wo_win_c & ~stall_i & ~sys_rst_i;
  assign any_gnt_c = ro_gnt_o | wo_gnt_o;

  // Pointer moves to the loser only when a contended grant is issued.
  always_comb begin
    rr_d = rr_q;
    if (contention_c && any_gnt_c) begin
      rr_d = ~rr_q;
    end
  end

  // Winning port's request drives the array.
  always_comb begin
    sel_wen   = ro_hdr.wen;
    sel_addr  = ro_hdr.addr;
    sel_be    = ro_be_i;
    sel_wdata = ro_wdata_i;
    if (wo_gnt_o) begin
      sel_wen   = wo_hdr.wen;
      sel_addr  = wo_hdr.addr;
      sel_be    = wo_be_i;
      sel_wdata = wo_wdata_i;
    end
  end

  // Addresses below BASE_ADDR wrap to large offsets and fail the bound check.
  always_comb begin
    offset   = sel_addr - BASE_ADDR;
    in_range = ({1'b0, offset} < MEM_BYTES);
    word_idx = AW'(offset >> BYTE_SHIFT);
  end

  udma_l2_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_sram (
    .clk_i   (sys_clk_i),
    .req_i   (any_gnt_c & in_range),
    .we_i    (~sel_wen),
    .addr_i  (word_idx),
    .be_i    (sel_be),
    .wdata_i (sel_wdata),
    .rdata_o (sram_rdata)
  );

  // Out-of-range pattern replicated across the word.
  always_comb begin
    oor_word = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      oor_word[i] = L2_OOR_PATTERN[5'(i)];
    end
  end

  // Response tags and held read data per port.
  always_comb begin
    ro_pend_d   = '{valid: ro_gnt_o, is_read: sel_wen, oor: ~in_range};
    wo_pend_d   = '{valid: wo_gnt_o, is_read: sel_wen, oor: ~in_range};
    ro_rsp_data = '0;
    wo_rsp_data = '0;
    if (ro_pend_q.is_read) ro_rsp_data = ro_pend_q.oor ? oor_word : sram_rdata;
    if (wo_pend_q.is_read) wo_rsp_data = wo_pend_q.oor ? oor_word : sram_rdata;
    ro_rdata_d  = ro_rvalid_o ? ro_rsp_data : ro_rdata_q;
    wo_rdata_d  = wo_rvalid_o ? wo_rsp_data : wo_rdata_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rr_q       <= 1'b0;
      ro_pend_q  <= '0;
      wo_pend_q  <= '0;
      ro_rdata_q <= '0;
      wo_rdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      ro_pend_q  <= ro_pend_d;
      wo_pend_q  <= wo_pend_d;
      ro_rdata_q <= ro_rdata_d;
      wo_rdata_q <= wo_rdata_d;
    end
  end

  // Reset masks responses immediately, including one already in flight.
  assign ro_rvalid_o = ro_pend_q.valid & ~sys_rst_i;
  assign wo_rvalid_o = wo_pend_q.valid & ~sys_rst_i;
  assign ro_rdata_o  = sys_rst_i ? '0 : (ro_pend_q.valid ? ro_rsp_data : ro_rdata_q);
  assign wo_rdata_o  = sys_rst_i ? '0 : (wo_pend_q.valid ? wo_rsp_data : wo_rdata_q);

endmodule

// File: doc/udma_l2_responder.md
UDMA_L2_RESPONDER -- requirements
Module: udma_l2_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the L2 word width (matches the uDMA L2_DATA_WIDTH).
REQ-002 SHALL have parameter NUM_WORDS, default 4096, meaning the memory depth in words (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1C00_0000, meaning the byte address mapped to word 0.
REQ-004 SHALL have a single clock and synchronous active-high reset: sys_clk_i and sys_rst_i.
REQ-005 sys_clk_i  input  1  clock for all state.
REQ-006 sys_rst_i  input  1  synchronous active-high reset.
REQ-007 stall_i  input  1  when high, no grant is issued on either port (bench backpressure).
REQ-008 ro_req_i  input  1  read-only port request from the uDMA.
REQ-009 ro_gnt_o  output  1  read-only port grant.
REQ-010 ro_wen_i  input  1  read-only port write enable, active-low (1 = read).
REQ-011 ro_addr_i  input  32  read-only port byte address.
REQ-012 ro_be_i  input  DATA_WIDTH/8  read-only port byte enables.
REQ-013 ro_wdata_i  input  DATA_WIDTH  read-only port write data.
REQ-014 ro_rvalid_o  output  1  read-only port response valid.
REQ-015 ro_rdata_o  output  DATA_WIDTH  read-only port response data.
REQ-016 wo_req_i  input  1  write-only port request from the uDMA.
REQ-017 wo_gnt_o  output  1  write-only port grant.
REQ-018 wo_wen_i  input  1  write-only port write enable, active-low (0 = write).
REQ-019 wo_addr_i  input  32  write-only port byte address.
REQ-020 wo_be_i  input  DATA_WIDTH/8  write-only port byte enables.
REQ-021 wo_wdata_i  input  DATA_WIDTH  write-only port write data.
REQ-022 wo_rvalid_o  output  1  write-only port response valid.
REQ-023 wo_rdata_o  output  DATA_WIDTH  write-only port response data.
REQ-024 Both ports SHALL be fully symmetric: either port may read or write, as selected by wen.

Function
REQ-025 Grant is combinational: x_gnt_o = x_req_i & arbitration winner & ~stall_i & ~sys_rst_i. At most one grant per cycle (single-ported array).
REQ-026 Arbitration: a lone requester always wins. On contention the winner is given by a 1-bit round-robin pointer rr_q (0 = ro, 1 = wo). rr_q updates only on a contention grant and then points to the loser.
REQ-027 x_rvalid_o SHALL assert for exactly one cycle, exactly one cycle after each x_gnt_o, for reads and writes alike. It SHALL never assert on the port that was not granted.
REQ-028 Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Address bits below word granularity are ignored.
REQ-029 In range means BASE_ADDR <= addr < BASE_ADDR + NUM_WORDS*DATA_WIDTH/8.
REQ-030 Write (wen=0), in range: on the grant edge, only bytes with be=1 are updated. Response rdata = 0.
REQ-031 Read (wen=1), in range: rdata = the word content before any same-cycle update. be is ignored.
REQ-032 Out of range: the request is still granted and answered. Writes are dropped. Reads return 32'hDEAD_BEEF (replicated for DATA_WIDTH>32).
REQ-033 Back-to-back accesses: a write granted in cycle N is visible to a read granted in cycle N+1.
REQ-034 x_rdata_o SHALL hold its value until the next rvalid on that port.

Reset
REQ-035 During reset: gnt=0, rvalid=0, rdata=0, rr_q=0 on both ports.
REQ-036 Memory contents are not reset. Reset asserted in the cycle after a grant suppresses that rvalid.

Structure
REQ-037 DATA_WIDTH default, the out-of-range pattern and the port request/response struct typedefs SHALL go in shared package udma_l2_resp_pkg.
REQ-038 The array SHALL be one sub-module, udma_l2_sram: a single-port RAM with byte enables and one-cycle read latency. Arbitration and response routing stay in the top.

Verification
REQ-039 ro reads 0x1C00_0010 with no contention -> ro_gnt_o same cycle; ro_rvalid_o next cycle with the preloaded word; wo_rvalid_o stays 0.
REQ-040 wo writes 0xAABBCCDD to 0x1C00_0004 with be=4'b0101 over 0x11223344, then ro reads the same address next cycle -> 0x11BB33DD.
REQ-041 Both ports request continuously for 6 cycles from reset -> grants alternate ro,wo,ro,wo,ro,wo; each port gets one rvalid per grant.
REQ-042 ro reads 0x1D00_0000 and wo writes to 0x0 -> both granted; ro_rdata_o = 0xDEAD_BEEF; memory unchanged on readback.
REQ-043 stall_i held high 3 cycles with ro_req_i=1 -> no gnt/rvalid; grant in the cycle stall_i drops.
REQ-044 sys_rst_i asserted the cycle after a wo grant -> wo_rvalid_o=0, rr_q=0, all outputs 0 during reset.
